// File: rtl/commit_stage_wide_if.sv
// Shared types and the commit-stage bus bundle.
// Combinational interface: no latency of its own.
// Backpressure is carried by commit_lsu_ready, no_st_pending and the acks.
package commit_stage_wide_pkg;
   typedef enum logic [3:0] {
      ADD, SUB, STORE, CSRRW, CSRRS, CSRRC, FENCE, FENCE_I, SFENCE_VMA
   } fu_op_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      fu_op_t      op;
      logic [6:0]  rd;
      logic [63:0] result;
      logic        valid;
      exception_t  ex;
   } scoreboard_entry_t;
endpackage

interface commit_stage_wide_if #(
   parameter int unsigned NR_COMMIT_PORTS = 4,
   parameter int unsigned MAX_STORES      = 1
);
   logic                                                    halt;
   logic                                                    flush_dcache;
   commit_stage_wide_pkg::scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr;
   logic [NR_COMMIT_PORTS-1:0]                              commit_instr_valid;
   logic [NR_COMMIT_PORTS-1:0]                              commit_ack;
   logic [NR_COMMIT_PORTS-1:0][6:0]                         waddr;
   logic [NR_COMMIT_PORTS-1:0][63:0]                        wdata;
   logic [NR_COMMIT_PORTS-1:0]                              we;
   commit_stage_wide_pkg::exception_t                       exception;
   commit_stage_wide_pkg::fu_op_t                           csr_op;
   logic [63:0]                                             csr_wdata;
   logic [63:0]                                             csr_rdata;
   commit_stage_wide_pkg::exception_t                       csr_exception;
   logic [MAX_STORES-1:0]                                   commit_lsu;
   logic [MAX_STORES-1:0]                                   commit_lsu_ready;
   logic                                                    no_st_pending;
   logic                                                    commit_csr;
   logic                                                    fence_i;
   logic                                                    fence;
   logic                                                    sfence_vma;
   logic [63:0]                                             instret;

   // Environment side: scoreboard, LSU, CSR file and controller.
   modport master (
      output halt, flush_dcache, commit_instr, commit_instr_valid, csr_rdata,
             csr_exception, commit_lsu_ready, no_st_pending,
      input  commit_ack, waddr, wdata, we, exception, csr_op, csr_wdata,
             commit_lsu, commit_csr, fence_i, fence, sfence_vma, instret
   );

   // Commit stage side.
   modport slave (
      input  halt, flush_dcache, commit_instr, commit_instr_valid, csr_rdata,
             csr_exception, commit_lsu_ready, no_st_pending,
      output commit_ack, waddr, wdata, we, exception, csr_op, csr_wdata,
             commit_lsu, commit_csr, fence_i, fence, sfence_vma, instret
   );
endinterface

// File: rtl/commit_stage_wide.sv
// In-order multi-port commit: retires the longest ready prefix of head entries.
// Acks/writes/exceptions are combinational; FSM state and instret update next edge.
// Stops the prefix on missing LSU lanes, serialising ops, and drains stores for fences.
module commit_stage_wide
   import commit_stage_wide_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 4,
   parameter int unsigned MAX_STORES      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   commit_stage_wide_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   state_t                     state, state_nxt;
   fu_op_t                     kind, kind_nxt;
   fu_op_t                     pulse_kind;
   logic                       pulse;
   logic                       active, head_vld, irq, stop, lane_found;
   logic [NR_COMMIT_PORTS-1:0] exc_slot;
   logic [MAX_STORES-1:0]      lane_used;
   logic [7:0]                 n_ret;
   logic [63:0]                instret;
   scoreboard_entry_t          entry;

   function automatic logic is_fence(input fu_op_t op);
      return (op == FENCE) || (op == FENCE_I) || (op == SFENCE_VMA);
   endfunction

   function automatic logic is_csr(input fu_op_t op);
      return (op == CSRRW) || (op == CSRRS) || (op == CSRRC);
   endfunction

   // Per-cycle retire decision, fence FSM next state and retire count.
   always_comb begin
      bus.commit_ack = '0;
      bus.we         = '0;
      bus.waddr      = '0;
      bus.wdata      = '0;
      bus.exception  = '0;
      bus.csr_op     = ADD;
      bus.csr_wdata  = '0;
      bus.commit_lsu = '0;
      bus.commit_csr = 1'b0;
      pulse          = 1'b0;
      pulse_kind     = kind;
      exc_slot       = '0;
      lane_used      = '0;
      lane_found     = 1'b0;
      stop           = 1'b0;
      state_nxt      = state;
      kind_nxt       = kind;
      entry          = '0;
      n_ret          = '0;

      active   = !rst && !bus.halt;
      head_vld = bus.commit_instr[0].valid && bus.commit_instr_valid[0];
      irq      = active && (state == IDLE) && head_vld &&
                 bus.csr_exception.valid && bus.csr_exception.cause[63];

      if (irq) begin
         // Interrupts take nothing from the window and override any exception.
         bus.exception      = bus.csr_exception;
         bus.exception.tval = '0;
      end else if (active && (state == IDLE)) begin
         for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            entry = bus.commit_instr[i];
            if (!stop) begin
               if (!(entry.valid && bus.commit_instr_valid[i])) begin
                  stop = 1'b1;
               end else if (entry.ex.valid) begin
                  bus.commit_ack[i] = 1'b1;
                  bus.exception     = entry.ex;
                  exc_slot[i]       = 1'b1;
                  stop              = 1'b1;
               end else if (is_fence(entry.op) || is_csr(entry.op) ||
                            (bus.flush_dcache && entry.op != STORE)) begin
                  // Serialising: only slot 0 may retire it, nothing behind it does.
                  stop = 1'b1;
                  if (i == 0) begin
                     if (is_csr(entry.op)) begin
                        bus.commit_ack[0] = 1'b1;
                        bus.commit_csr    = 1'b1;
                        bus.csr_op        = entry.op;
                        bus.csr_wdata     = entry.result;
                        bus.waddr[0]      = entry.rd;
                        bus.wdata[0]      = bus.csr_rdata;
                        if (bus.csr_exception.valid) begin
                           bus.exception      = bus.csr_exception;
                           bus.exception.tval = entry.ex.tval;
                           exc_slot[0]        = 1'b1;
                        end else begin
                           bus.we[0] = 1'b1;
                        end
                     end else begin
                        // A pending D$ flush rides on this instruction as FENCE_I.
                        kind_nxt = is_fence(entry.op) ? entry.op : FENCE_I;
                        if (bus.no_st_pending) begin
                           bus.commit_ack[0] = 1'b1;
                           if (!is_fence(entry.op)) begin
                              bus.we[0]    = 1'b1;
                              bus.waddr[0] = entry.rd;
                              bus.wdata[0] = entry.result;
                           end
                           pulse      = 1'b1;
                           pulse_kind = kind_nxt;
                           state_nxt  = FLUSH;
                        end else begin
                           state_nxt = DRAIN;
                        end
                     end
                  end
               end else if (entry.op == STORE) begin
                  lane_found = 1'b0;
                  for (int k = 0; k < int'(MAX_STORES); k++) begin
                     if (!lane_found && bus.commit_lsu_ready[k] && !lane_used[k]) begin
                        lane_found        = 1'b1;
                        lane_used[k]      = 1'b1;
                        bus.commit_lsu[k] = 1'b1;
                     end
                  end
                  if (lane_found) bus.commit_ack[i] = 1'b1;
                  else            stop = 1'b1;
               end else begin
                  bus.commit_ack[i] = 1'b1;
                  bus.we[i]         = 1'b1;
                  bus.waddr[i]      = entry.rd;
                  bus.wdata[i]      = entry.result;
               end
            end
         end
      end else if (active && (state == DRAIN)) begin
         if (!head_vld) begin
            state_nxt = IDLE;
         end else if (bus.no_st_pending) begin
            bus.commit_ack[0] = 1'b1;
            pulse             = 1'b1;
            pulse_kind        = kind;
            state_nxt         = FLUSH;
         end
      end else if (active && (state == FLUSH)) begin
         state_nxt = IDLE;
      end

      bus.fence      = pulse && (pulse_kind == FENCE);
      bus.fence_i    = pulse && (pulse_kind == FENCE_I);
      bus.sfence_vma = pulse && (pulse_kind == SFENCE_VMA);

      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
         if (bus.commit_ack[i] && !exc_slot[i]) n_ret = n_ret + 8'd1;
      end
   end

   // Fence FSM state, pending fence flavour and retired-instruction counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         kind    <= FENCE;
         instret <= '0;
      end else begin
         state   <= state_nxt;
         kind    <= kind_nxt;
         instret <= instret + 64'(n_ret);
      end
   end

   assign bus.instret = instret;

endmodule

// File: tb/tb_commit_stage_wide.sv
// Directed bench for commit_stage_wide: retire prefix, stores, exceptions, fences, CSR, IRQ, reset.
// Checks sampled 1 time unit after inputs change, mid-cycle.
// LSU readiness and store-buffer state driven directly by the bench.
module tb_commit_stage_wide;
   import commit_stage_wide_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   commit_stage_wide_if #(.NR_COMMIT_PORTS(4), .MAX_STORES(1)) bus();

   commit_stage_wide #(.NR_COMMIT_PORTS(4), .MAX_STORES(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic scoreboard_entry_t mk(input fu_op_t op, input logic [6:0] rd,
                                            input logic [63:0] res);
      scoreboard_entry_t e;
      e        = '0;
      e.op     = op;
      e.rd     = rd;
      e.result = res;
      e.valid  = 1'b1;
      return e;
   endfunction

   task automatic set4(input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                       input scoreboard_entry_t e2, input scoreboard_entry_t e3);
      bus.commit_instr[0]    = e0;
      bus.commit_instr[1]    = e1;
      bus.commit_instr[2]    = e2;
      bus.commit_instr[3]    = e3;
      bus.commit_instr_valid = 4'hf;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_alu();
      set4(mk(ADD, 7'd1, 64'h101), mk(ADD, 7'd2, 64'h102),
           mk(ADD, 7'd3, 64'h103), mk(ADD, 7'd4, 64'h104));
   endtask

   initial begin
      scoreboard_entry_t e;
      rst                  = 1'b1;
      bus.halt             = 1'b0;
      bus.flush_dcache     = 1'b0;
      bus.csr_rdata        = '0;
      bus.csr_exception    = '0;
      bus.commit_lsu_ready = 1'b1;
      bus.no_st_pending    = 1'b1;
      all_alu();

      // Reset holds everything idle even with ready entries.
      #3;
      chk("rst_ack", 64'(bus.commit_ack), 64'h0);
      chk("rst_instret", bus.instret, 64'd0);
      chk("rst_csr_op", 64'(bus.csr_op), 64'(ADD));
      chk("rst_exc_valid", 64'(bus.exception.valid), 64'd0);

      // Four ready ALU ops retire together.
      #9 rst = 1'b0;
      #1;
      chk("alu4_ack", 64'(bus.commit_ack), 64'hf);
      chk("alu4_we", 64'(bus.we), 64'hf);
      chk("alu4_waddr3", 64'(bus.waddr[3]), 64'd4);
      chk("alu4_wdata0", bus.wdata[0], 64'h101);
      tick();
      chk("alu4_instret", bus.instret, 64'd4);

      // ALU, store, store, ALU with one store lane.
      set4(mk(ADD, 7'd1, 64'h1), mk(STORE, 7'd0, 64'h0),
           mk(STORE, 7'd0, 64'h0), mk(ADD, 7'd4, 64'h4));
      #1;
      chk("st_ack", 64'(bus.commit_ack), 64'h3);
      chk("st_lsu", 64'(bus.commit_lsu), 64'h1);
      chk("st_we", 64'(bus.we), 64'h1);
      tick();
      chk("st_instret", bus.instret, 64'd6);

      // No free lane: store blocks the prefix.
      bus.commit_lsu_ready = 1'b0;
      #1;
      chk("stblk_ack", 64'(bus.commit_ack), 64'h1);
      chk("stblk_lsu", 64'(bus.commit_lsu), 64'h0);
      tick();
      chk("stblk_instret", bus.instret, 64'd7);
      bus.commit_lsu_ready = 1'b1;

      // Exception in slot 2.
      all_alu();
      e = mk(ADD, 7'd3, 64'h103);
      e.ex.valid = 1'b1;
      e.ex.cause = 64'd2;
      bus.commit_instr[2] = e;
      #1;
      chk("exc_ack", 64'(bus.commit_ack), 64'h7);
      chk("exc_we", 64'(bus.we), 64'h3);
      chk("exc_valid", 64'(bus.exception.valid), 64'd1);
      chk("exc_cause", bus.exception.cause, 64'd2);
      tick();
      chk("exc_instret", bus.instret, 64'd9);

      // Halt suppresses everything.
      all_alu();
      bus.halt = 1'b1;
      #1;
      chk("halt_ack", 64'(bus.commit_ack), 64'h0);
      chk("halt_we", 64'(bus.we), 64'h0);
      tick();
      chk("halt_instret", bus.instret, 64'd9);
      bus.halt = 1'b0;

      // FENCE with store buffer busy: drain, then pulse, flush, idle.
      set4(mk(FENCE, 7'd0, 64'h0), mk(ADD, 7'd2, 64'h2),
           mk(ADD, 7'd3, 64'h3), mk(ADD, 7'd4, 64'h4));
      bus.no_st_pending = 1'b0;
      #1;
      chk("fence_idle_ack", 64'(bus.commit_ack), 64'h0);
      chk("fence_idle_pulse", 64'(bus.fence), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("drain_ack", 64'(bus.commit_ack), 64'h0);
         chk("drain_pulse", 64'(bus.fence), 64'd0);
      end
      bus.no_st_pending = 1'b1;
      #1;
      chk("drain_done_ack", 64'(bus.commit_ack), 64'h1);
      chk("drain_done_fence", 64'(bus.fence), 64'd1);
      tick();
      all_alu();
      #1;
      chk("flush_ack", 64'(bus.commit_ack), 64'h0);
      chk("flush_pulse", 64'(bus.fence), 64'd0);
      chk("fence_instret", bus.instret, 64'd10);
      tick();
      chk("resume_ack", 64'(bus.commit_ack), 64'hf);
      tick();
      chk("resume_instret", bus.instret, 64'd14);

      // CSR behind an ALU op, then in slot 0.
      set4(mk(ADD, 7'd1, 64'h1), mk(CSRRW, 7'd5, 64'h77),
           mk(ADD, 7'd3, 64'h3), mk(ADD, 7'd4, 64'h4));
      #1;
      chk("csr1_ack", 64'(bus.commit_ack), 64'h1);
      chk("csr1_commit", 64'(bus.commit_csr), 64'd0);
      tick();
      set4(mk(CSRRW, 7'd5, 64'h77), mk(ADD, 7'd3, 64'h3),
           mk(ADD, 7'd4, 64'h4), mk(ADD, 7'd6, 64'h6));
      bus.csr_rdata = 64'hdead;
      #1;
      chk("csr0_ack", 64'(bus.commit_ack), 64'h1);
      chk("csr0_commit", 64'(bus.commit_csr), 64'd1);
      chk("csr0_wdata", bus.wdata[0], 64'hdead);
      chk("csr0_we", 64'(bus.we), 64'h1);
      chk("csr0_op", 64'(bus.csr_op), 64'(CSRRW));
      chk("csr0_csr_wdata", bus.csr_wdata, 64'h77);
      tick();
      chk("csr_instret", bus.instret, 64'd16);

      // CSR raising a synchronous exception.
      e = mk(CSRRS, 7'd5, 64'h1);
      e.ex.tval = 64'h55;
      bus.commit_instr[0] = e;
      bus.csr_exception.valid = 1'b1;
      bus.csr_exception.cause = 64'd2;
      bus.csr_exception.tval  = 64'h99;
      #1;
      chk("csrexc_ack", 64'(bus.commit_ack), 64'h1);
      chk("csrexc_we", 64'(bus.we), 64'h0);
      chk("csrexc_tval", bus.exception.tval, 64'h55);
      chk("csrexc_cause", bus.exception.cause, 64'd2);
      tick();
      chk("csrexc_instret", bus.instret, 64'd16);

      // Interrupt with four ready ops.
      all_alu();
      bus.csr_exception.cause = 64'h8000_0000_0000_0007;
      #1;
      chk("irq_ack", 64'(bus.commit_ack), 64'h0);
      chk("irq_valid", 64'(bus.exception.valid), 64'd1);
      chk("irq_cause", bus.exception.cause, 64'h8000_0000_0000_0007);
      chk("irq_tval", bus.exception.tval, 64'h0);
      tick();
      chk("irq_instret", bus.instret, 64'd16);
      bus.csr_exception = '0;

      // SFENCE.VMA with store buffer empty.
      set4(mk(SFENCE_VMA, 7'd0, 64'h0), mk(ADD, 7'd2, 64'h2),
           mk(ADD, 7'd3, 64'h3), mk(ADD, 7'd4, 64'h4));
      #1;
      chk("sfence_ack", 64'(bus.commit_ack), 64'h1);
      chk("sfence_pulse", 64'(bus.sfence_vma), 64'd1);
      chk("sfence_not_fence", 64'(bus.fence), 64'd0);
      tick();
      chk("sfence_flush_ack", 64'(bus.commit_ack), 64'h0);
      chk("sfence_instret", bus.instret, 64'd17);
      tick();

      // D$ flush with a store in slot 0: store first, flush on the next non-store.
      set4(mk(STORE, 7'd0, 64'h0), mk(ADD, 7'd2, 64'h2),
           mk(ADD, 7'd3, 64'h3), mk(ADD, 7'd4, 64'h4));
      bus.flush_dcache = 1'b1;
      #1;
      chk("fl_st_ack", 64'(bus.commit_ack), 64'h1);
      chk("fl_st_lsu", 64'(bus.commit_lsu), 64'h1);
      chk("fl_st_fence_i", 64'(bus.fence_i), 64'd0);
      tick();
      set4(mk(ADD, 7'd2, 64'h2), mk(ADD, 7'd3, 64'h3),
           mk(ADD, 7'd4, 64'h4), mk(ADD, 7'd5, 64'h5));
      #1;
      chk("fl_alu_ack", 64'(bus.commit_ack), 64'h1);
      chk("fl_alu_fence_i", 64'(bus.fence_i), 64'd1);
      tick();
      bus.flush_dcache = 1'b0;
      #1;
      chk("fl_flush_ack", 64'(bus.commit_ack), 64'h0);
      chk("fl_instret", bus.instret, 64'd19);
      tick();

      // Asynchronous reset in the middle of DRAIN.
      set4(mk(FENCE, 7'd0, 64'h0), mk(ADD, 7'd2, 64'h2),
           mk(ADD, 7'd3, 64'h3), mk(ADD, 7'd4, 64'h4));
      bus.no_st_pending = 1'b0;
      tick();
      chk("rd_drain_ack", 64'(bus.commit_ack), 64'h0);
      #2 rst = 1'b1;
      #1;
      chk("rd_rst_instret", bus.instret, 64'd0);
      chk("rd_rst_ack", 64'(bus.commit_ack), 64'h0);
      #2 rst = 1'b0;
      all_alu();
      bus.no_st_pending = 1'b1;
      #1;
      chk("rd_idle_ack", 64'(bus.commit_ack), 64'hf);
      tick();
      chk("rd_instret", bus.instret, 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
